aer_out_fifo: RTL and testbench

AER_OUT_FIFO -- requirements
Module: aer_out_fifo

---
 rtl/aer_pkg.sv | 30 +++
 rtl/aer_evt_fifo.sv | 68 ++++++
 rtl/aer_out_fifo.sv | 196 +++++++++++++++++++
 tb/tb_aer_out_fifo.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aer_pkg.sv
// ---------------------------------------------------------------------------
// aer_pkg -- shared definitions for the AER output path.
//   * aer_state_e : handshake FSM states of aer_out_fifo
//   * aer_ret_e   : where WAIT_LOW goes once the acknowledge has dropped
//   * AW_* / DEPTH_* : supported ranges of the AW and DEPTH parameters
// ---------------------------------------------------------------------------
package aer_pkg;

  localparam int AW_MIN    = 4;
  localparam int AW_MAX    = 16;
  localparam int DEPTH_MIN = 2;
  localparam int DEPTH_MAX = 64;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MON_HI   = 3'd1,
    ST_MON_LO   = 3'd2,
    ST_EVT      = 3'd3,
    ST_EVT_TS   = 3'd4,
    ST_WAIT_LOW = 3'd5
  } aer_state_e;

  typedef enum logic [1:0] {
    RET_IDLE     = 2'd0,
    RET_MON_LO   = 2'd1,
    RET_MON_DONE = 2'd2,
    RET_EVT_TS   = 2'd3
  } aer_ret_e;

endpackage

// File: rtl/aer_evt_fifo.sv
// ---------------------------------------------------------------------------
// aer_evt_fifo -- synchronous event FIFO, power-of-two depth.
// Ports:
//   CLK, rst_activity      : clock, async active-high reset (pointers/level)
//   push_i, wr_data_i      : write request/data (ignored while full)
//   pop_i                  : read request (ignored while empty)
//   rd_data_o              : head entry (combinational)
//   level_o, full_o, empty_o : occupancy
// Storage is not reset; only pointers and level are.
// ---------------------------------------------------------------------------
module aer_evt_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                     CLK,
  input  logic                     rst_activity,
  input  logic                     push_i,
  input  logic [W-1:0]             wr_data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             rd_data_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);
  import aer_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_LVL = (PW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [PW:0]   level_q, level_d;
  logic          do_push, do_pop;

  assign full_o    = (level_q == FULL_LVL);
  assign empty_o   = (level_q == '0);
  assign level_o   = level_q;
  assign rd_data_o = mem_q[rptr_q];
  assign do_push   = push_i && !full_o;
  assign do_pop    = pop_i && !empty_o;

  always_comb begin
    level_d = level_q;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + (PW+1)'(1);
      2'b01:   level_d = level_q - (PW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK or posedge rst_activity) begin
    if (rst_activity) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PW'(1);
      if (do_pop)  rptr_q <= rptr_q + PW'(1);
      level_q <= level_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/aer_out_fifo.sv
// ---------------------------------------------------------------------------
// aer_out_fifo -- buffers spike events and monitor packets and sends them
// over a 4-phase AER request/acknowledge link.
// Ports:
//   CLK, rst_activity          : clock, async active-high reset
//   EVT_VALID/EVT_ADDR/EVT_READY : spike event input (READY = FIFO not full)
//   MON_EN/MON_VALID/MON_DATA/MON_READY : 2-word monitor packet input
//   FIFO_LEVEL, OVERFLOW       : occupancy and sticky drop flag
//   AEROUT_CTRL_BUSY           : FSM active or data pending
//   AEROUT_ADDR/REQ/ACK        : AER output link (ACK is asynchronous)
// Build option: define AER_OUT_TSTAMP_EN to append a timestamp word to
// every event (FIFO stores {addr, timestamp}).
// ---------------------------------------------------------------------------
module aer_out_fifo #(
  parameter int AW          = 8,
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   CLK,
  input  logic                   rst_activity,
  input  logic                   EVT_VALID,
  input  logic [AW-1:0]          EVT_ADDR,
  output logic                   EVT_READY,
  input  logic                   MON_EN,
  input  logic                   MON_VALID,
  input  logic [2*AW-1:0]        MON_DATA,
  output logic                   MON_READY,
  output logic [$clog2(DEPTH):0] FIFO_LEVEL,
  output logic                   OVERFLOW,
  output logic                   AEROUT_CTRL_BUSY,
  output logic [AW-1:0]          AEROUT_ADDR,
  output logic                   AEROUT_REQ,
  input  logic                   AEROUT_ACK
);
  import aer_pkg::*;

`ifdef AER_OUT_TSTAMP_EN
  localparam int FW = 2 * AW;
`else
  localparam int FW = AW;
`endif

  aer_state_e             state_q, state_d;
  aer_ret_e               ret_q, ret_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic                   req_q, req_d;
  logic [2*AW-1:0]        mon_buf_q;
  logic                   mon_full_q, mon_clr;
  logic                   overflow_q;
  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic                   ack_s;
  logic                   fifo_pop, fifo_full, fifo_empty;
  logic [FW-1:0]          fifo_wr, fifo_rd;
  logic [AW-1:0]          head_addr;

`ifdef AER_OUT_TSTAMP_EN
  logic [AW-1:0] ts_cnt_q, ts_q, ts_d;
  assign fifo_wr = {EVT_ADDR, ts_cnt_q};
`else
  assign fifo_wr = EVT_ADDR;
`endif
  assign head_addr = fifo_rd[FW-1 -: AW];

  aer_evt_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
    .CLK          (CLK),
    .rst_activity (rst_activity),
    .push_i       (EVT_VALID),
    .wr_data_i    (fifo_wr),
    .pop_i        (fifo_pop),
    .rd_data_o    (fifo_rd),
    .level_o      (FIFO_LEVEL),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty)
  );

  assign ack_s            = ack_sync_q[SYNC_STAGES-1];
  assign EVT_READY        = !fifo_full;
  assign MON_READY        = !mon_full_q;
  assign OVERFLOW         = overflow_q;
  assign AEROUT_REQ       = req_q;
  assign AEROUT_ADDR      = addr_q;
  assign AEROUT_CTRL_BUSY = (state_q != ST_IDLE) || !fifo_empty || mon_full_q;

  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    addr_d   = addr_q;
    req_d    = req_q;
    fifo_pop = 1'b0;
    mon_clr  = 1'b0;
`ifdef AER_OUT_TSTAMP_EN
    ts_d     = ts_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // Monitor packet wins over queued events.
        if (mon_full_q) begin
          state_d = ST_MON_HI;
          addr_d  = mon_buf_q[2*AW-1:AW];
          req_d   = 1'b1;
        end else if (!fifo_empty && !ack_s) begin
          state_d  = ST_EVT;
          addr_d   = head_addr;
          req_d    = 1'b1;
          fifo_pop = 1'b1;
`ifdef AER_OUT_TSTAMP_EN
          ts_d     = fifo_rd[AW-1:0];
`endif
        end
      end
      ST_MON_HI, ST_MON_LO, ST_EVT, ST_EVT_TS: begin
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = ST_WAIT_LOW;
          case (state_q)
            ST_MON_HI: ret_d = RET_MON_LO;
            ST_MON_LO: ret_d = RET_MON_DONE;
`ifdef AER_OUT_TSTAMP_EN
            ST_EVT:    ret_d = RET_EVT_TS;
`endif
            default:   ret_d = RET_IDLE;
          endcase
        end
      end
      ST_WAIT_LOW: begin
        if (!ack_s) begin
          case (ret_q)
            RET_MON_LO: begin
              state_d = ST_MON_LO;
              addr_d  = mon_buf_q[AW-1:0];
              req_d   = 1'b1;
            end
            RET_MON_DONE: begin
              state_d = ST_IDLE;
              mon_clr = 1'b1;
            end
            RET_EVT_TS: begin
`ifdef AER_OUT_TSTAMP_EN
              state_d = ST_EVT_TS;
              addr_d  = ts_q;
              req_d   = 1'b1;
`else
              state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
          endcase
        end
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge rst_activity) begin
    if (rst_activity) begin
      state_q    <= ST_IDLE;
      ret_q      <= RET_IDLE;
      addr_q     <= '0;
      req_q      <= 1'b0;
      ack_sync_q <= '0;
      overflow_q <= 1'b0;
      mon_buf_q  <= '0;
      mon_full_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], AEROUT_ACK};
      if (EVT_VALID && fifo_full) overflow_q <= 1'b1;
      // Clearing only happens while full, so it never races a new latch.
      if (mon_clr) begin
        mon_full_q <= 1'b0;
      end else if (MON_VALID && MON_EN && !mon_full_q) begin
        mon_buf_q  <= MON_DATA;
        mon_full_q <= 1'b1;
      end
    end
  end

`ifdef AER_OUT_TSTAMP_EN
  always_ff @(posedge CLK or posedge rst_activity) begin
    if (rst_activity) begin
      ts_cnt_q <= '0;
      ts_q     <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + AW'(1);
      ts_q     <= ts_d;
    end
  end
`endif

endmodule

// File: tb/tb_aer_out_fifo.sv
// ---------------------------------------------------------------------------
// tb_aer_out_fifo -- self-checking bench for aer_out_fifo (default build).
// A behavioural AER receiver captures every word at REQ rise; expected
// word streams come from a queue model of the event/monitor rules.
// ---------------------------------------------------------------------------
module tb_aer_out_fifo;
  localparam int AW    = 8;
  localparam int DEPTH = 8;
  localparam int SYNC  = 2;

  logic          CLK = 1'b0;
  logic          rst_activity = 1'b0;
  logic          EVT_VALID = 1'b0;
  logic [AW-1:0] EVT_ADDR = '0;
  logic          EVT_READY;
  logic          MON_EN = 1'b0;
  logic          MON_VALID = 1'b0;
  logic [2*AW-1:0] MON_DATA = '0;
  logic          MON_READY;
  logic [$clog2(DEPTH):0] FIFO_LEVEL;
  logic          OVERFLOW;
  logic          AEROUT_CTRL_BUSY;
  logic [AW-1:0] AEROUT_ADDR;
  logic          AEROUT_REQ;
  logic          AEROUT_ACK;

  logic ack_resp = 1'b0;
  logic ack_force = 1'b0;
  bit   resp_en = 1'b1;
  int   resp_dly = 3;
  assign AEROUT_ACK = ack_resp | ack_force;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] cap_q[$];
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] ra;

  always #5 CLK = ~CLK;

  aer_out_fifo #(.AW(AW), .DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .CLK              (CLK),
    .rst_activity     (rst_activity),
    .EVT_VALID        (EVT_VALID),
    .EVT_ADDR         (EVT_ADDR),
    .EVT_READY        (EVT_READY),
    .MON_EN           (MON_EN),
    .MON_VALID        (MON_VALID),
    .MON_DATA         (MON_DATA),
    .MON_READY        (MON_READY),
    .FIFO_LEVEL       (FIFO_LEVEL),
    .OVERFLOW         (OVERFLOW),
    .AEROUT_CTRL_BUSY (AEROUT_CTRL_BUSY),
    .AEROUT_ADDR      (AEROUT_ADDR),
    .AEROUT_REQ       (AEROUT_REQ),
    .AEROUT_ACK       (AEROUT_ACK)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // 4-phase receiver: capture word at REQ rise, raise ACK after resp_dly
  // cycles, release it resp_dly cycles after REQ falls.
  always begin
    @(negedge CLK);
    if (resp_en && AEROUT_REQ && !ack_resp) begin
      ra = AEROUT_ADDR;
      cap_q.push_back(ra);
      repeat (resp_dly) @(negedge CLK);
      ack_resp = 1'b1;
      for (int i = 0; i < 200 && AEROUT_REQ; i++) @(negedge CLK);
      if (AEROUT_REQ) check("req_drop_timeout", 32'd0, 32'd1);
      else            check("addr_stable", AEROUT_ADDR, ra);
      repeat (resp_dly) @(negedge CLK);
      ack_resp = 1'b0;
    end
  end

  task automatic reset_dut();
    @(negedge CLK);
    rst_activity = 1'b1;
    EVT_VALID = 1'b0; MON_VALID = 1'b0; MON_EN = 1'b0;
    ack_force = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_req",   AEROUT_REQ, 0);
    check("rst_addr",  AEROUT_ADDR, 0);
    check("rst_busy",  AEROUT_CTRL_BUSY, 0);
    check("rst_level", FIFO_LEVEL, 0);
    check("rst_ovf",   OVERFLOW, 0);
    rst_activity = 1'b0;
    @(negedge CLK);
    cap_q.delete();
    exp_q.delete();
  endtask

  task automatic push_evt(input logic [AW-1:0] a);
    EVT_VALID = 1'b1;
    EVT_ADDR  = a;
    @(negedge CLK);
    EVT_VALID = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int quiet;
    quiet = 0;
    for (int i = 0; i < max_cyc && quiet < 4; i++) begin
      @(negedge CLK);
      if (!AEROUT_CTRL_BUSY && !AEROUT_REQ && !ack_resp) quiet++;
      else quiet = 0;
    end
    if (quiet < 4) check("drain_timeout", 32'd0, 32'd1);
  endtask

  // Stream = expected events in order, with the monitor pair (hi, lo)
  // inserted contiguously somewhere if a packet was accepted.
  function automatic bit stream_ok(input bit mon, input logic [AW-1:0] hi, input logic [AW-1:0] lo);
    bit ok;
    int k;
    if (!mon) begin
      if (cap_q.size() != exp_q.size()) return 1'b0;
      foreach (exp_q[i]) if (cap_q[i] !== exp_q[i]) return 1'b0;
      return 1'b1;
    end
    if (cap_q.size() != exp_q.size() + 2) return 1'b0;
    for (int p = 0; p + 1 < cap_q.size(); p++) begin
      if (cap_q[p] === hi && cap_q[p+1] === lo) begin
        ok = 1'b1;
        k = 0;
        for (int j = 0; j < cap_q.size(); j++) begin
          if (j != p && j != p + 1) begin
            if (cap_q[j] !== exp_q[k]) ok = 1'b0;
            k++;
          end
        end
        if (ok) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  initial begin
    int n, seen, t;
    bit mon;
    logic [2*AW-1:0] md;
    logic [AW-1:0] a;

    // Single event, ACK echoes after 3 cycles.
    reset_dut();
    resp_dly = 3;
    push_evt(8'h2A);
    for (t = 0; t < 200 && !ack_resp; t++) @(negedge CLK);
    for (t = 0; t < 200 && ack_resp; t++) @(negedge CLK);
    for (t = 0; t < SYNC + 4 && AEROUT_CTRL_BUSY; t++) @(negedge CLK);
    check("t037_busy_clear", AEROUT_CTRL_BUSY, 0);
    wait_idle(300);
    check("t037_count", cap_q.size(), 1);
    if (cap_q.size() > 0) check("t037_addr", cap_q[0], 8'h2A);

    // Overflow: ACK held high so nothing leaves, then drain.
    reset_dut();
    ack_force = 1'b1;
    repeat (SYNC + 2) @(negedge CLK);
    for (int i = 0; i < 9; i++) begin
      check("t038_ready", EVT_READY, (i < 8) ? 1 : 0);
      push_evt(AW'(8'h10 + i));
    end
    check("t038_level", FIFO_LEVEL, 8);
    check("t038_ovf", OVERFLOW, 1);
    ack_force = 1'b0;
    wait_idle(3000);
    check("t038_count", cap_q.size(), 8);
    for (int i = 0; i < 8 && i < cap_q.size(); i++) check("t038_word", cap_q[i], 8'h10 + i);
    check("t038_ovf_sticky", OVERFLOW, 1);

    // Monitor packet before queued events.
    reset_dut();
    MON_EN = 1'b1; MON_VALID = 1'b1; MON_DATA = 16'hA55A;
    EVT_VALID = 1'b1; EVT_ADDR = 8'h31;
    @(negedge CLK);
    MON_VALID = 1'b0; EVT_VALID = 1'b0;
    push_evt(8'h32);
    push_evt(8'h33);
    wait_idle(3000);
    exp_q = '{8'hA5, 8'h5A, 8'h31, 8'h32, 8'h33};
    check("t039_count", cap_q.size(), 5);
    for (int i = 0; i < 5 && i < cap_q.size(); i++) check("t039_word", cap_q[i], exp_q[i]);

    // Monitor disabled.
    reset_dut();
    MON_EN = 1'b0; MON_VALID = 1'b1; MON_DATA = 16'h1234;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("t042_mon_ready", MON_READY, 1);
    end
    MON_VALID = 1'b0;
    repeat (20) @(negedge CLK);
    check("t042_count", cap_q.size(), 0);
    check("t042_busy", AEROUT_CTRL_BUSY, 0);

    // Reset while REQ is high.
    reset_dut();
    resp_en = 1'b0;
    push_evt(8'h55);
    for (t = 0; t < 20 && !AEROUT_REQ; t++) @(negedge CLK);
    check("t040_req_rise", AEROUT_REQ, 1);
    #2 rst_activity = 1'b1;
    #1;
    check("t040_req", AEROUT_REQ, 0);
    check("t040_busy", AEROUT_CTRL_BUSY, 0);
    check("t040_level", FIFO_LEVEL, 0);
    @(negedge CLK);
    rst_activity = 1'b0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (AEROUT_REQ) seen++;
    end
    check("t040_no_req", seen, 0);
    resp_en = 1'b1;

    // Randomised rounds: burst with possible overflow, optional monitor.
    for (int r = 0; r < 6; r++) begin
      reset_dut();
      resp_dly = $urandom_range(1, 4);
      ack_force = 1'b1;
      repeat (SYNC + 2) @(negedge CLK);
      n = $urandom_range(1, DEPTH + 2);
      for (int i = 0; i < n; i++) begin
        a = AW'($urandom);
        if (exp_q.size() < DEPTH) exp_q.push_back(a);
        push_evt(a);
        repeat ($urandom_range(0, 2)) @(negedge CLK);
      end
      check("rnd_level", FIFO_LEVEL, exp_q.size());
      check("rnd_ovf", OVERFLOW, (n > DEPTH) ? 1 : 0);
      check("rnd_ready", EVT_READY, (exp_q.size() < DEPTH) ? 1 : 0);
      ack_force = 1'b0;
      repeat (SYNC + 2) @(negedge CLK);
      repeat ($urandom_range(0, 30)) @(negedge CLK);
      mon = 1'($urandom_range(0, 1));
      md = (2*AW)'($urandom);
      MON_EN = mon; MON_VALID = 1'b1; MON_DATA = md;
      @(negedge CLK);
      MON_VALID = 1'b0;
      wait_idle(4000);
      check("rnd_stream", stream_ok(mon, md[2*AW-1:AW], md[AW-1:0]), 1);
      check("rnd_len", cap_q.size(), exp_q.size() + (mon ? 2 : 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
